pn_seq_gen: RTL and testbench
=============================

Name: pn_seq_gen

Overview:
- Parametrised Fibonacci LFSR pseudo-noise generator.
- Replaces the fixed 7-bit, 1-bit-per-clock PN source with configurable polynomial length, tap mask and seed, plus an OUT_W-bit parallel output per beat.
- Adds a valid/ready stream output, runtime seed load, enable and all-zero lockup recovery.
- Feeds modulator/scrambler test paths and the BER checker in the same datapath.

Parameters:
- N, 7, LFSR length in bits (3..32); state bits s[1..N].
- TAPS, 7'h4E, feedback mask; bit k-1 set means s[k] is XORed into feedback (default taps 7,4,3,2).
- SEED, 7'h41, reset/recovery state; bit k-1 = s[k] (default s[1]=1, s[7]=1); must be nonzero.
- OUT_W, 8, bits produced per output beat (1..64).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- en  in  1  generation enable; 0 freezes LFSR and fills no new word.
- seed_load  in  1  one-cycle pulse; load seed_in into LFSR.
- seed_in  in  N  runtime seed, same bit mapping as SEED.
- dout  out  OUT_W  PN word; dout[0] is the earliest serial bit.
- dout_valid  out  1  dout holds a valid word.
- dout_ready  in  1  consumer accepts the word when dout_valid && dout_ready.
- lockup  out  1  sticky: an all-zero seed was loaded and replaced.

Behaviour:
- Serial step: out bit = s[N]; fb = XOR of s[k] where TAPS[k-1]=1; s[1]<=fb; s[k]<=s[k-1] for k=2..N.
- One word = OUT_W consecutive serial steps, unrolled combinationally within one cycle. Bit j of the word is s[N] after j steps. The LFSR advances OUT_W steps per word generated.
- Reset (reset_n=0 at clk edge): s<=SEED, dout<=0, dout_valid<=0, lockup<=0.
- Fill condition: en && (!dout_valid || dout_ready) && !seed_load. On fill, dout<=next word, dout_valid<=1, LFSR advances OUT_W steps.
- Drain: dout_valid && dout_ready && !fill gives dout_valid<=0 next cycle.
- Latency: first valid word appears 1 cycle after the first fill-eligible cycle (reset released, en=1).
- Backpressure: while dout_valid=1 and dout_ready=0, dout and LFSR hold exactly. No word is lost or skipped.
- Throughput: one word per cycle while en=1 and dout_ready=1.
- en=0: LFSR and dout hold. A pending valid word stays valid and may still be consumed.
- seed_load (highest priority after reset):
  - s<=seed_in, dout_valid<=0; any held word is discarded, even if dout_ready=1 that cycle.
  - Generation resumes next cycle from the new seed.
- seed_in all-zero: s<=SEED instead, lockup<=1. lockup clears only on reset.
- Reset mid-stream or asserted together with seed_load: reset wins; state returns to SEED.
- Period: 2^N-1 serial bits when TAPS is primitive; word alignment then wraps per period mod OUT_W. No checking of TAPS is performed.
- With N=7, TAPS=7'h4E, SEED=7'h41: serial sequence begins 1,0,0,0,0,0,1,1.

Optional Feature:
- Macro PN_ERR_INJECT_EN.
- Defined:
  - Input port err_inject (1 bit) exists. A pulse arms a single-shot flag; the next filled word has dout[0] inverted, then the flag clears.
  - The LFSR state is not corrupted; later words are unaffected.
  - err_inject coincident with a fill cycle applies to that fill.
  - Flag cleared by reset and by seed_load.
- Undefined: port absent, no injection logic; dout is always the pure sequence.

Test Plan:
- Defaults; reset 3 cycles, then en=1, dout_ready=1 -> dout_valid rises 1 cycle after release, first dout=8'hC1, one new word per cycle thereafter.
- OUT_W=1, defaults; collect 254 beats -> beats 0..126 equal beats 127..253; beat 0 = 1; each beat equals the reference serial LFSR model.
- Hold dout_ready=0 for 10 cycles mid-stream -> dout and dout_valid stable throughout; after release the word sequence is contiguous, with none dropped or duplicated.
- seed_load with seed_in=7'h00 -> dout_valid=0 next cycle, lockup=1, next word = 8'hC1; lockup stays 1 through subsequent seed_load of 7'h41.
- seed_load with seed_in=7'h41 while dout_valid=1 and dout_ready=1 -> held word discarded (not counted as transferred), next word = 8'hC1.
- With PN_ERR_INJECT_EN: err_inject pulse -> exactly one word has dout[0] inverted vs the model (e.g. 8'hC1 becomes 8'hC0 if it hits the first word), all later words match the model.

Source files
------------

// File: rtl/pn_seq_gen.sv
// ---------------------------------------------------------------------------
// pn_seq_gen : parametrised Fibonacci LFSR pseudo-noise generator.
//
// Each generated word holds OUT_W consecutive serial LFSR bits. dout[0] is the
// earliest bit. The word is offered on a valid/ready stream. The generator
// also supports a runtime seed load, an enable, and recovery from an all-zero
// seed.
//
// Optional build macro: PN_ERR_INJECT_EN
//   When this macro is defined, the design gains an err_inject input. A pulse
//   on err_inject arms a single-shot flag. The next filled word then has
//   dout[0] inverted. The LFSR state itself is never corrupted.
//
// Parameters
//   N     : LFSR length (3..32). State bit k-1 holds s[k].
//   TAPS  : feedback mask. Bit k-1 set means s[k] feeds the XOR.
//   SEED  : reset and recovery state. Must be nonzero.
//   OUT_W : serial bits per output word (1..64).
//
// Ports
//   clk        : clock, rising edge
//   reset_n    : synchronous active-low reset
//   en         : generation enable
//   seed_load  : one-cycle pulse, loads seed_in
//   seed_in    : runtime seed (same mapping as SEED)
//   dout       : PN word
//   dout_valid : dout holds a valid word
//   dout_ready : consumer accepts the word when valid && ready
//   err_inject : (PN_ERR_INJECT_EN only) arm a single dout[0] inversion
//   lockup     : sticky flag, an all-zero seed was replaced by SEED
// ---------------------------------------------------------------------------
module pn_seq_gen #(
  parameter int          N     = 7,
  parameter logic [N-1:0] TAPS = 7'h4E,
  parameter logic [N-1:0] SEED = 7'h41,
  parameter int          OUT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             seed_load,
  input  logic [N-1:0]     seed_in,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
`ifdef PN_ERR_INJECT_EN
  input  logic             err_inject,
`endif
  output logic             lockup
);

  // One serial step: s[1] <= feedback, s[k] <= s[k-1].
  function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] s);
    return {s[N-2:0], ^(s & TAPS)};
  endfunction

  logic [N-1:0]     r_state;
  logic [OUT_W-1:0] r_dout;
  logic             r_valid;
  logic             r_lockup;
  logic [N-1:0]     w_next_state;
  logic [OUT_W-1:0] w_word;
  logic             w_fill;
  logic             w_inj;

`ifdef PN_ERR_INJECT_EN
  logic r_inj_armed;
  // A pulse that coincides with a fill is applied to that same fill.
  assign w_inj = r_inj_armed | err_inject;
`else
  assign w_inj = 1'b0;
`endif

  // A new word is produced when the output slot is free or being drained.
  // A seed_load suppresses the fill for that cycle.
  assign w_fill = en & (~r_valid | dout_ready) & ~seed_load;

  // Unroll OUT_W serial steps. Word bit j is s[N] after j steps.
  always_comb begin
    logic [N-1:0] v_s;
    v_s    = r_state;
    w_word = {OUT_W{1'b0}};
    for (int j = 0; j < OUT_W; j++) begin
      w_word[j] = v_s[N-1];
      v_s       = lfsr_step(v_s);
    end
    w_next_state = v_s;
  end

  // LFSR state, output word, and stream and status flags.
  // Priority: reset, then seed_load, then fill, then drain.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= SEED;
      r_dout   <= {OUT_W{1'b0}};
      r_valid  <= 1'b0;
      r_lockup <= 1'b0;
    end else if (seed_load) begin
      // An all-zero state would lock the LFSR, so substitute SEED instead.
      if (seed_in == {N{1'b0}}) begin
        r_state  <= SEED;
        r_lockup <= 1'b1;
      end else begin
        r_state <= seed_in;
      end
      r_valid <= 1'b0;
    end else if (w_fill) begin
      r_state <= w_next_state;
      r_dout  <= {w_word[OUT_W-1:0]} ^ {{(OUT_W-1){1'b0}}, w_inj};
      r_valid <= 1'b1;
    end else if (r_valid && dout_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

`ifdef PN_ERR_INJECT_EN
  // Single-shot injection flag. Reset and seed_load clear it; a fill consumes it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_inj_armed <= 1'b0;
    end else if (seed_load || w_fill) begin
      r_inj_armed <= 1'b0;
    end else begin
      r_inj_armed <= r_inj_armed | err_inject;
    end
  end
`endif

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign lockup     = r_lockup;

endmodule

// File: tb/tb_pn_seq_gen.sv
module tb_pn_seq_gen;

  logic       clk;
  logic       reset_n;
  logic       en;
  logic       seed_load;
  logic [6:0] seed_in;
  logic       dout_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       lockup;
  logic [0:0] dout1;
  logic       dout_valid1;
  logic       lockup1;
`ifdef PN_ERR_INJECT_EN
  logic       err_inject;
`endif

  int checks = 0;
  int errors = 0;

  // Reference serial model, s[1..7], taps 7,4,3,2
  logic m_s [1:7];
  logic [7:0] exp_w;
  logic [7:0] held;
  logic       beats [0:253];
  logic       b;

  pn_seq_gen u_dut (
    .clk(clk), .reset_n(reset_n), .en(en), .seed_load(seed_load),
    .seed_in(seed_in), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready),
`ifdef PN_ERR_INJECT_EN
    .err_inject(err_inject),
`endif
    .lockup(lockup)
  );

  pn_seq_gen #(.OUT_W(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .en(en), .seed_load(seed_load),
    .seed_in(seed_in), .dout(dout1), .dout_valid(dout_valid1),
    .dout_ready(dout_ready),
`ifdef PN_ERR_INJECT_EN
    .err_inject(err_inject),
`endif
    .lockup(lockup1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_seed(input logic [6:0] v);
    for (int k = 1; k <= 7; k++) m_s[k] = v[k-1];
  endtask

  task automatic model_bit(output logic ob);
    logic fb;
    ob = m_s[7];
    fb = m_s[2] ^ m_s[3] ^ m_s[4] ^ m_s[7];
    for (int k = 7; k >= 2; k--) m_s[k] = m_s[k-1];
    m_s[1] = fb;
  endtask

  task automatic model_word(output logic [7:0] w);
    logic ob;
    for (int j = 0; j < 8; j++) begin
      model_bit(ob);
      w[j] = ob;
    end
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b0; seed_load = 1'b0; seed_in = 7'h00; dout_ready = 1'b0;
`ifdef PN_ERR_INJECT_EN
    err_inject = 1'b0;
`endif
    // Reset state
    tick(); tick(); tick();
    check("rst_valid", 64'(dout_valid), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_lockup", 64'(lockup), 64'd0);

    // Release reset: first word appears one cycle later
    reset_n = 1'b1; en = 1'b1; dout_ready = 1'b1;
    model_seed(7'h41);
    tick();
    check("first_valid", 64'(dout_valid), 64'd1);
    check("first_word", 64'(dout), 64'hC1);
    model_word(exp_w);
    check("model_first", 64'(exp_w), 64'hC1);
    tick();
    check("second_word", 64'(dout), 64'h85);
    model_word(exp_w);
    for (int i = 0; i < 5; i++) begin
      tick();
      model_word(exp_w);
      check("stream_word", 64'(dout), 64'(exp_w));
      check("stream_valid", 64'(dout_valid), 64'd1);
    end

    // Backpressure: word and valid hold for 10 cycles
    held = exp_w;
    dout_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_dout", 64'(dout), 64'(held));
      check("bp_valid", 64'(dout_valid), 64'd1);
    end
    dout_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      model_word(exp_w);
      check("bp_resume", 64'(dout), 64'(exp_w));
    end

    // en=0: the pending word drains and dout holds
    en = 1'b0;
    tick();
    check("drain_valid", 64'(dout_valid), 64'd0);
    check("drain_dout", 64'(dout), 64'(exp_w));
    tick();
    check("idle_dout", 64'(dout), 64'(exp_w));
    en = 1'b1;
    tick();
    model_word(exp_w);
    check("en_resume", 64'(dout), 64'(exp_w));

    // All-zero seed: SEED substituted, lockup sticky
    seed_load = 1'b1; seed_in = 7'h00;
    tick();
    check("zseed_valid", 64'(dout_valid), 64'd0);
    check("zseed_lockup", 64'(lockup), 64'd1);
    seed_load = 1'b0;
    tick();
    check("zseed_word", 64'(dout), 64'hC1);
    check("zseed_wvalid", 64'(dout_valid), 64'd1);

    // seed_load while valid && ready: held word discarded
    seed_load = 1'b1; seed_in = 7'h41;
    tick();
    check("sl_discard", 64'(dout_valid), 64'd0);
    check("sl_lockup", 64'(lockup), 64'd1);
    seed_load = 1'b0;
    tick();
    check("sl_word", 64'(dout), 64'hC1);
    tick();
    check("sl_word2", 64'(dout), 64'h85);

    // Arbitrary runtime seed
    seed_load = 1'b1; seed_in = 7'h01;
    model_seed(7'h01);
    tick();
    seed_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      model_word(exp_w);
      check("seed01_word", 64'(dout), 64'(exp_w));
    end

    // Reset together with seed_load: reset wins
    reset_n = 1'b0; seed_load = 1'b1; seed_in = 7'h55;
    tick();
    check("rst_sl_valid", 64'(dout_valid), 64'd0);
    check("rst_sl_lockup", 64'(lockup), 64'd0);
    reset_n = 1'b1; seed_load = 1'b0;
`ifdef PN_ERR_INJECT_EN
    err_inject = 1'b1;
`endif
    tick();
`ifdef PN_ERR_INJECT_EN
    err_inject = 1'b0;
    check("inj_word", 64'(dout), 64'hC0);
    tick();
    check("inj_after", 64'(dout), 64'h85);
`else
    check("rst_sl_word", 64'(dout), 64'hC1);
`endif

    // OUT_W=1 instance: serial sequence and period 127
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    model_seed(7'h41);
    for (int i = 0; i < 254; i++) begin
      tick();
      beats[i] = dout1[0];
      model_bit(b);
      check("serial_bit", 64'(dout1[0]), 64'(b));
    end
    check("serial_beat0", 64'(beats[0]), 64'd1);
    for (int i = 0; i < 127; i++) begin
      check("serial_period", 64'(beats[i + 127]), 64'(beats[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
